// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Turns the UART receiver's byte stream into framed packets of the form
// SYNC, LEN, LEN payload bytes, CHK (XOR of LEN and payload). One good
// frame is held for a downstream consumer, which reads it by address and
// releases it with frame_ack. Bad frames are dropped with a one-cycle error
// pulse. Bytes arriving while a frame is held are dropped with an overrun pulse.
module uart_rx_frame_ctrl #(
    parameter int           MAX_LEN     = 16,
    parameter logic [7:0]   SYNC_BYTE   = 8'hA5,
    parameter int           TIMEOUT_CYC = 50000,
    parameter int           AW          = $clog2(MAX_LEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            frame_valid,
    output logic [7:0]      frame_len,
    input  logic [AW-1:0]   rd_addr,
    output logic [7:0]      rd_data,
    input  logic            frame_ack,
    output logic            err_len,
    output logic            err_chk,
    output logic            err_tmo,
    output logic            overrun
);

    // Inter-byte idle counter must be able to reach TIMEOUT_CYC-1.
    localparam int            CW        = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Frame-in-progress bookkeeping
    logic [7:0]      len;
    logic [7:0]      chk;
    logic [7:0]      idx;
    logic [CW-1:0]   tmo_cnt;

    // Payload buffer, deliberately not reset
    logic [7:0]      mem [MAX_LEN];

    // Decoded conditions
    logic            in_frame;
    logic            len_bad;
    logic            last_byte;
    logic            chk_ok;
    logic            tmo_hit;

    // Next-cycle values of the registered pulses
    logic            err_len_nxt;
    logic            err_chk_nxt;
    logic            err_tmo_nxt;
    logic            overrun_nxt;

    assign in_frame  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
    assign len_bad   = (byte_data == 8'd0) || (byte_data > MAX_LEN_B);
    assign last_byte = (idx == (len - 8'd1));
    assign chk_ok    = (byte_data == chk);
    // A byte arriving on the final allowed idle cycle still counts as on time.
    assign tmo_hit   = in_frame && !byte_valid && (tmo_cnt == TMO_LAST);

    // The held frame is the HOLD state itself; it is visible the cycle after
    // the checksum byte and drops the cycle after frame_ack.
    assign frame_valid = (state == S_HOLD);

    // Random-access read of the held payload; out-of-range or idle reads
    // return whatever the RAM last held.
    assign rd_data = mem[rd_addr];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and error/overrun pulse requests
    always_comb begin
        state_nxt   = state;
        err_len_nxt = 1'b0;
        err_chk_nxt = 1'b0;
        err_tmo_nxt = 1'b0;
        overrun_nxt = 1'b0;

        case (state)
            S_HUNT: begin
                if (byte_valid && (byte_data == SYNC_BYTE)) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_valid) begin
                    if (len_bad) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = S_HUNT;
                    end else begin
                        state_nxt   = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                // SYNC_BYTE is ordinary data here; only the length ends payload.
                if (byte_valid && last_byte) begin
                    state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (byte_valid) begin
                    if (chk_ok) begin
                        state_nxt   = S_HOLD;
                    end else begin
                        err_chk_nxt = 1'b1;
                        state_nxt   = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                // No room for a second frame: anything arriving is lost.
                if (byte_valid) begin
                    overrun_nxt = 1'b1;
                end
                if (frame_ack) begin
                    state_nxt = S_HUNT;
                end
            end
            default: begin
                state_nxt = S_HUNT;
            end
        endcase

        // Timeout only fires on byte-free cycles, so it never coincides with
        // a length or checksum error.
        if (tmo_hit) begin
            err_tmo_nxt = 1'b1;
            state_nxt   = S_HUNT;
        end
    end

    // Registered one-cycle error and overrun pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            err_len <= 1'b0;
            err_chk <= 1'b0;
            err_tmo <= 1'b0;
            overrun <= 1'b0;
        end else begin
            err_len <= err_len_nxt;
            err_chk <= err_chk_nxt;
            err_tmo <= err_tmo_nxt;
            overrun <= overrun_nxt;
        end
    end

    // Length, running checksum, payload index and published frame length
    always_ff @(posedge clk) begin
        if (rst) begin
            len       <= 8'd0;
            chk       <= 8'd0;
            idx       <= 8'd0;
            frame_len <= 8'd0;
        end else if (byte_valid) begin
            case (state)
                S_LEN: begin
                    if (!len_bad) begin
                        len <= byte_data;
                        chk <= byte_data;
                        idx <= 8'd0;
                    end
                end
                S_PAYLOAD: begin
                    chk <= chk ^ byte_data;
                    idx <= idx + 8'd1;
                end
                S_CHK: begin
                    // frame_len keeps the last good length until the next one.
                    if (chk_ok) begin
                        frame_len <= len;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Inter-byte idle counter: runs only inside a frame, restarts on every byte
    always_ff @(posedge clk) begin
        if (rst || byte_valid || !in_frame || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    // Payload write port; the buffer is only written while collecting payload,
    // so a held frame is never disturbed.
    always_ff @(posedge clk) begin
        if (!rst && byte_valid && (state == S_PAYLOAD)) begin
            mem[idx[AW-1:0]] <= byte_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed frames with literal expectations,
// then randomized frame traffic, all compared every cycle against a
// queue-based frame parser model.
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN     = 16;
    localparam int         TIMEOUT_CYC = 100;
    localparam logic [7:0] SYNC        = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       frame_valid;
    logic [7:0] frame_len;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_ack = 1'b0;
    logic       err_len;
    logic       err_chk;
    logic       err_tmo;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;

    uart_rx_frame_ctrl #(
        .MAX_LEN    (MAX_LEN),
        .SYNC_BYTE  (SYNC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .AW         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_valid(frame_valid),
        .frame_len  (frame_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_ack  (frame_ack),
        .err_len    (err_len),
        .err_chk    (err_chk),
        .err_tmo    (err_tmo),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model: bytes of the frame being collected
    logic [7:0] q[$];
    logic [7:0] hdata [16];
    bit         m_held = 1'b0;
    logic [7:0] m_len  = 8'd0;
    int         idle   = 0;
    bit         e_len = 1'b0, e_chk = 1'b0, e_tmo = 1'b0, e_ovr = 1'b0;

    always @(posedge clk) begin : model
        logic [7:0] x;
        e_len = 1'b0; e_chk = 1'b0; e_tmo = 1'b0; e_ovr = 1'b0;
        if (rst) begin
            q.delete();
            m_held = 1'b0;
            m_len  = 8'd0;
            idle   = 0;
        end else if (m_held) begin
            if (byte_valid) e_ovr = 1'b1;
            if (frame_ack)  m_held = 1'b0;
        end else if (byte_valid) begin
            idle = 0;
            if (q.size() == 0) begin
                if (byte_data == SYNC) q.push_back(byte_data);
            end else begin
                q.push_back(byte_data);
                if (q.size() == 2 && (q[1] == 8'd0 || int'(q[1]) > MAX_LEN)) begin
                    e_len = 1'b1;
                    q.delete();
                end else if (q.size() > 2 && q.size() == int'(q[1]) + 3) begin
                    x = 8'd0;
                    for (int i = 1; i < q.size() - 1; i++) x ^= q[i];
                    if (x == q[q.size()-1]) begin
                        m_held = 1'b1;
                        m_len  = q[1];
                        for (int i = 0; i < int'(q[1]); i++) hdata[i] = q[i+2];
                    end else begin
                        e_chk = 1'b1;
                    end
                    q.delete();
                end
            end
        end else if (q.size() > 0) begin
            idle++;
            if (idle == TIMEOUT_CYC) begin
                e_tmo = 1'b1;
                q.delete();
                idle = 0;
            end
        end
    end

    // ---------------- every-cycle comparison against the model
    always @(negedge clk) begin
        check("frame_valid", frame_valid, m_held);
        check("frame_len",   frame_len,   m_len);
        check("err_len",     err_len,     e_len);
        check("err_chk",     err_chk,     e_chk);
        check("err_tmo",     err_tmo,     e_tmo);
        check("overrun",     overrun,     e_ovr);
        if (m_held && (rd_addr < m_len)) check("rd_data", rd_data, hdata[rd_addr]);
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            rd_addr   = 4'($urandom_range(0, 15));
            frame_ack = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    logic [7:0] frm[$];
    logic [7:0] c;
    logic [7:0] exp1 [3];
    int         kind;
    int         l;
    int         gap;

    initial begin
        exp1[0] = 8'h11; exp1[1] = 8'h22; exp1[2] = 8'h33;
        idle_cyc(3);
        rst = 1'b0;
        check("lit_reset_valid", frame_valid, 0);
        check("lit_reset_len",   frame_len,   0);
        idle_cyc(2);

        // Good frame, readback
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        check("lit_t1_valid", frame_valid, 1);
        check("lit_t1_len",   frame_len,   3);
        for (int i = 0; i < 3; i++) begin
            rd_addr = 4'(i);
            tick();
            check("lit_t1_rd", rd_data, exp1[i]);
        end

        // Overrun while held, then byte with ack in the same cycle
        send_byte(8'h55);
        check("lit_t5_ovr", overrun, 1);
        rd_addr = 4'd1;
        tick();
        check("lit_t5_rd", rd_data, 8'h22);
        byte_valid = 1'b1; byte_data = 8'h66; frame_ack = 1'b1;
        tick();
        byte_valid = 1'b0; frame_ack = 1'b0;
        check("lit_t5_ovr2",  overrun,     1);
        check("lit_t5_valid", frame_valid, 0);
        idle_cyc(2);

        // Garbage then bad checksum, then a good one-byte frame
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hFF);
        check("lit_t2_chk", err_chk, 1);
        tick();
        check("lit_t2_chk_once", err_chk, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        rd_addr = 4'd0;
        tick();
        check("lit_t2_valid", frame_valid, 1);
        check("lit_t2_rd",    rd_data,     8'h7E);
        ack();

        // Length errors and a maximum-length frame
        send_byte(8'hA5); send_byte(8'h00);
        check("lit_t3_len0", err_len, 1);
        send_byte(8'hA5); send_byte(8'h11);
        check("lit_t3_len17", err_len, 1);
        send_byte(8'hA5); send_byte(8'h10);
        c = 8'h10;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i * 7 + 3));
            c ^= 8'(i * 7 + 3);
        end
        send_byte(c);
        check("lit_t3_len16", frame_len, 16);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            tick();
            check("lit_t3_rd", rd_data, 8'(i * 7 + 3));
        end
        ack();

        // Timeout after 100 idle cycles; a byte on the last allowed cycle is fine
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        idle_cyc(TIMEOUT_CYC - 1);
        check("lit_t4_no_tmo_yet", err_tmo, 0);
        tick();
        check("lit_t4_tmo", err_tmo, 1);
        tick();
        check("lit_t4_tmo_once", err_tmo, 0);
        send_byte(8'h20); send_byte(8'h32);
        tick();
        check("lit_t4_hunt", frame_valid, 0);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        idle_cyc(TIMEOUT_CYC - 1);
        send_byte(8'h20);
        check("lit_t4_edge_no_tmo", err_tmo, 0);
        send_byte(8'h32);
        check("lit_t4_edge_valid", frame_valid, 1);
        check("lit_t4_edge_len",   frame_len,   2);
        ack();
        check("lit_ack_drop", frame_valid, 0);

        // Reset in the middle of a payload
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("lit_t6_len",   frame_len,   0);
        check("lit_t6_valid", frame_valid, 0);
        check("lit_t6_errs",  {err_len, err_chk, err_tmo, overrun}, 0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hAB);
        rd_addr = 4'd0;
        tick();
        check("lit_t6_valid2", frame_valid, 1);
        check("lit_t6_rd",     rd_data,     8'hAA);
        ack();

        // Randomized frame traffic with random acks, reads, gaps and faults
        rand_mode = 1'b1;
        repeat (300) begin
            frm.delete();
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                repeat ($urandom_range(1, 3)) frm.push_back(8'($urandom));
            end else begin
                frm.push_back(SYNC);
                if (kind == 1) begin
                    l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
                    frm.push_back(8'(l));
                end else begin
                    l = int'($urandom_range(1, MAX_LEN));
                    frm.push_back(8'(l));
                    c = 8'(l);
                    for (int i = 0; i < l; i++) begin
                        frm.push_back(8'($urandom));
                        c ^= frm[frm.size()-1];
                    end
                    if (kind == 2) c ^= 8'($urandom_range(1, 255));
                    frm.push_back(c);
                end
            end
            foreach (frm[i]) begin
                send_byte(frm[i]);
                gap = ($urandom_range(0, 40) == 0) ? int'($urandom_range(TIMEOUT_CYC - 5, TIMEOUT_CYC + 5))
                                                   : int'($urandom_range(0, 3));
                idle_cyc(gap);
            end
        end
        rand_mode = 1'b0;
        frame_ack = 1'b0;
        idle_cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
